// File: rtl/alu_op_scheduler_if.sv
// rtl/alu_op_scheduler_if.sv - requester, ALU and result signals of the shared-ALU scheduler
interface alu_op_scheduler_if #(parameter int CNT_W = 8);
    logic             req0_valid;
    logic             req0_ready;
    logic [9:0]       req0_word;
    logic             req1_valid;
    logic             req1_ready;
    logic [9:0]       req1_word;
    logic [3:0]       alu_i1;
    logic [3:0]       alu_i2;
    logic [1:0]       alu_ctrl;
    logic [6:0]       alu_o;
    logic             res_valid;
    logic             res_ready;
    logic [6:0]       res_data;
    logic             res_id;
    logic [1:0]       res_op;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_word, req1_valid, req1_word, alu_o, res_ready,
        output req0_ready, req1_ready, alu_i1, alu_i2, alu_ctrl,
               res_valid, res_data, res_id, res_op, busy, op_count
    );

    modport master (
        output req0_valid, req0_word, req1_valid, req1_word, alu_o, res_ready,
        input  req0_ready, req1_ready, alu_i1, alu_i2, alu_ctrl,
               res_valid, res_data, res_id, res_op, busy, op_count
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - round-robin sharing of one combinational 4-bit ALU between two requesters
module alu_op_scheduler #(
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_scheduler_if.slave   bus
);
    localparam int WW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nx;

    logic             last_id;
    logic             cur_id;
    logic             grant_id;
    logic             rdy0, rdy1;
    logic             accept, capture, complete;
    logic [9:0]       grant_word;
    logic [WW-1:0]    wait_cnt;
    logic [3:0]       i1_q, i2_q;
    logic [1:0]       ctrl_q;
    logic             res_valid_q;
    logic [6:0]       res_data_q;
    logic             res_id_q;
    logic [1:0]       res_op_q;
    logic [CNT_W-1:0] op_count_q;

    // On contention the requester not served last wins; last_id resets to 1 so req0 goes first.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = ~last_id;
        else if (bus.req1_valid)
            grant_id = 1'b1;
    end

    assign rdy0       = rst_n && (state == IDLE) && bus.req0_valid && !grant_id;
    assign rdy1       = rst_n && (state == IDLE) && bus.req1_valid && grant_id;
    assign accept     = rdy0 || rdy1;
    assign grant_word = grant_id ? bus.req1_word : bus.req0_word;
    assign capture    = (state == WAIT) && (wait_cnt == WW'(1));
    assign complete   = (state == DONE) && res_valid_q && bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = WAIT;
            WAIT:    if (capture)  state_nx = DONE;
            DONE:    if (complete) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand registers only change on accept, so the ALU inputs stay clean between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id     <= 1'b1;
            cur_id      <= 1'b0;
            wait_cnt    <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            ctrl_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_op_q    <= '0;
            op_count_q  <= '0;
        end else begin
            if (accept) begin
                ctrl_q   <= grant_word[9:8];
                i1_q     <= grant_word[7:4];
                i2_q     <= grant_word[3:0];
                cur_id   <= grant_id;
                last_id  <= grant_id;
                wait_cnt <= WW'(ALU_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WW'(1);
            end
            if (capture) begin
                res_data_q  <= bus.alu_o;
                res_id_q    <= cur_id;
                res_op_q    <= ctrl_q;
                res_valid_q <= 1'b1;
            end
            if (complete) begin
                res_valid_q <= 1'b0;
                op_count_q  <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.alu_i1     = i1_q;
    assign bus.alu_i2     = i2_q;
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_op     = res_op_q;
    assign bus.busy       = (state != IDLE);
    assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - directed self-checking bench for alu_op_scheduler
module tb_alu_op_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_op_scheduler_if #(.CNT_W(8)) a ();
    alu_op_scheduler_if #(.CNT_W(2)) b ();

    alu_op_scheduler #(.ALU_LAT(2), .CNT_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    alu_op_scheduler #(.ALU_LAT(1), .CNT_W(2)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: add for ctrl 00, low 7 bits of product for ctrl 10
    always_comb begin
        case (a.alu_ctrl)
            2'b00:   a.alu_o = {3'b000, a.alu_i1} + {3'b000, a.alu_i2};
            2'b10:   a.alu_o = 7'({4'b0000, a.alu_i1} * {4'b0000, a.alu_i2});
            default: a.alu_o = 7'd0;
        endcase
    end
    always_comb begin
        case (b.alu_ctrl)
            2'b00:   b.alu_o = {3'b000, b.alu_i1} + {3'b000, b.alu_i2};
            2'b10:   b.alu_o = 7'({4'b0000, b.alu_i1} * {4'b0000, b.alu_i2});
            default: b.alu_o = 7'd0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a.req0_valid = 1'b1; a.req0_word = 10'b00_0110_0010;
        a.req1_valid = 1'b0; a.req1_word = 10'd0;
        a.res_ready  = 1'b1;
        b.req0_valid = 1'b0; b.req0_word = 10'd0;
        b.req1_valid = 1'b0; b.req1_word = 10'd0;
        b.res_ready  = 1'b1;
        step(); step();
        checks++;
        if (a.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", a.req0_ready); end
        checks++;
        if (a.busy !== 1'b0 || a.res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_busy_valid got %0b/%0b want 0/0", a.busy, a.res_valid);
        end
        checks++;
        if ({a.alu_i1, a.alu_i2, a.alu_ctrl, a.res_data, a.res_id, a.res_op, a.op_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_regs got i1=%0d i2=%0d c=%0d d=%0d id=%0d op=%0d cnt=%0d want all 0",
                     a.alu_i1, a.alu_i2, a.alu_ctrl, a.res_data, a.res_id, a.res_op, a.op_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (a.req0_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b want 1", a.req0_ready); end
    endtask

    task automatic test_single();
        step();
        a.req0_valid = 1'b0;
        checks++;
        if (a.alu_i1 !== 4'd6 || a.alu_i2 !== 4'd2 || a.alu_ctrl !== 2'd0 || a.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_operands got i1=%0d i2=%0d c=%0d busy=%0b want 6 2 0 1",
                     a.alu_i1, a.alu_i2, a.alu_ctrl, a.busy);
        end
        step();
        checks++;
        if (a.res_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", a.res_valid); end
        step();
        checks++;
        if (a.res_valid !== 1'b1 || a.res_data !== 7'd8 || a.res_id !== 1'b0 || a.res_op !== 2'd0) begin
            errors++;
            $display("FAIL single_result got v=%0b d=%0d id=%0d op=%0d want 1 8 0 0",
                     a.res_valid, a.res_data, a.res_id, a.res_op);
        end
        step();
        checks++;
        if (a.res_valid !== 1'b0 || a.op_count !== 8'd1 || a.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got v=%0b cnt=%0d busy=%0b want 0 1 0", a.res_valid, a.op_count, a.busy);
        end
    endtask

    task automatic test_backpressure();
        a.res_ready  = 1'b0;
        a.req1_word  = 10'b00_0011_0001;
        a.req1_valid = 1'b1;
        step();
        a.req1_valid = 1'b0;
        a.req0_word  = 10'b10_1111_1111;
        a.req0_valid = 1'b1;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (a.res_valid !== 1'b1 || a.res_data !== 7'd4 || a.res_id !== 1'b1 || a.res_op !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b d=%0d id=%0d op=%0d want 1 4 1 0",
                         k, a.res_valid, a.res_data, a.res_id, a.res_op);
            end
            checks++;
            if (a.req0_ready !== 1'b0 || a.req1_ready !== 1'b0 || a.alu_i1 !== 4'd3) begin
                errors++;
                $display("FAIL bp_noaccept[%0d] got r0=%0b r1=%0b i1=%0d want 0 0 3",
                         k, a.req0_ready, a.req1_ready, a.alu_i1);
            end
            step();
        end
        a.req0_valid = 1'b0;
        a.res_ready  = 1'b1;
        step();
        checks++;
        if (a.res_valid !== 1'b0 || a.busy !== 1'b0 || a.op_count !== 8'd2 || a.res_data !== 7'd4) begin
            errors++;
            $display("FAIL bp_release got v=%0b busy=%0b cnt=%0d d=%0d want 0 0 2 4",
                     a.res_valid, a.busy, a.op_count, a.res_data);
        end
    endtask

    task automatic test_arbitration();
        int n;
        a.req0_word  = 10'b10_0110_0010;
        a.req1_word  = 10'b00_0011_0001;
        a.req0_valid = 1'b1;
        a.req1_valid = 1'b1;
        a.res_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            step();
            while (a.res_valid !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            checks++;
            if (a.res_valid !== 1'b1) begin
                errors++; $display("FAIL arb_timeout[%0d] got no res_valid want res_valid within 20 cycles", k);
            end else if (a.res_id !== 1'(k % 2) || a.res_data !== ((k % 2) == 1 ? 7'd4 : 7'd12)) begin
                errors++;
                $display("FAIL arb_order[%0d] got id=%0d d=%0d want id=%0d d=%0d",
                         k, a.res_id, a.res_data, k % 2, (k % 2) == 1 ? 4 : 12);
            end
        end
        step();
        a.req0_valid = 1'b0;
        a.req1_valid = 1'b0;
        checks++;
        if (a.op_count !== 8'd6 || a.busy !== 1'b0) begin
            errors++; $display("FAIL arb_count got cnt=%0d busy=%0b want 6 0", a.op_count, a.busy);
        end
    endtask

    task automatic test_midop_reset();
        a.req0_word  = 10'b00_0110_0010;
        a.req0_valid = 1'b1;
        step();
        a.req0_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (a.busy !== 1'b0 || a.res_valid !== 1'b0 || a.op_count !== 8'd0 ||
            {a.alu_i1, a.alu_i2, a.alu_ctrl} !== 10'd0) begin
            errors++;
            $display("FAIL midreset got busy=%0b v=%0b cnt=%0d i1=%0d i2=%0d c=%0d want all 0",
                     a.busy, a.res_valid, a.op_count, a.alu_i1, a.alu_i2, a.alu_ctrl);
        end
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (a.res_valid !== 1'b0 || a.busy !== 1'b0) begin
                errors++; $display("FAIL midreset_after[%0d] got v=%0b busy=%0b want 0 0", k, a.res_valid, a.busy);
            end
        end
    endtask

    task automatic test_wrap_latency();
        logic [9:0] words [4];
        logic [6:0] exp_data [4];
        words[0] = 10'b00_0001_0010; exp_data[0] = 7'd3;
        words[1] = 10'b10_0101_0101; exp_data[1] = 7'd25;
        words[2] = 10'b00_1111_1111; exp_data[2] = 7'd30;
        words[3] = 10'b10_1111_1111; exp_data[3] = 7'd97;
        b.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b.req0_word  = words[k];
            b.req0_valid = 1'b1;
            step();
            b.req0_valid = 1'b0;
            checks++;
            if (b.busy !== 1'b1 || b.res_valid !== 1'b0) begin
                errors++; $display("FAIL wrap_accept[%0d] got busy=%0b v=%0b want 1 0", k, b.busy, b.res_valid);
            end
            step();
            checks++;
            if (b.res_valid !== 1'b1 || b.res_data !== exp_data[k]) begin
                errors++;
                $display("FAIL wrap_result[%0d] got v=%0b d=%0d want 1 %0d", k, b.res_valid, b.res_data, exp_data[k]);
            end
            step();
            checks++;
            if (b.op_count !== 2'(k + 1)) begin
                errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", k, b.op_count, (k + 1) % 4);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_arbitration();
        test_midop_reset();
        test_wrap_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
